median_bitserial: RTL and testbench

- Parametrised successor to the team's combinational 9-input bitwise-majority block.
- Accepts a block of N unsigned samples serially over a valid/ready stream and buffers them internally.
- Computes the exact median of the block with an MSB-first bit-serial radix selection, one bit per cycle.
- Keeps a legacy mode that outputs the bitwise majority instead. Sits between the pixel/sample stream source and downstream filtering logic.

---
 rtl/median_bitserial_if.sv | 33 +++
 rtl/median_bitserial.sv | 199 +++++++++++++++++++
 tb/tb_median_bitserial.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/median_bitserial_if.sv
// Sample-in / result-out stream bundle for median_bitserial.
// The design sits on the slave side; the sample source and result sink sit on the master side.
interface median_bitserial_if #(
  parameter int WIDTH = 16
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  mode,
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport master (
    output mode,
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

// File: rtl/median_bitserial.sv
// Block median (or legacy bitwise majority) of N unsigned samples.
// Samples are buffered during LOAD. SEARCH then resolves the median one bit per
// cycle, MSB first, by narrowing a candidate mask while tracking the rank still
// wanted inside it. In majority mode SEARCH takes a single cycle. DONE presents
// the result one cycle after entry and holds it until it is accepted.
module median_bitserial #(
  parameter int WIDTH = 16,
  parameter int N     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  median_bitserial_if.slave    bus
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = $clog2(WIDTH);

  if ((N % 2) != 1 || N < 3 || N > 15) begin : g_bad_n
    $error("median_bitserial: N must be odd and within 3..15");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("median_bitserial: WIDTH must be within 2..32");
  end

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Number of set bits in an N-wide vector; never exceeds N, so CW bits suffice.
  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] acc;
    acc = {CW{1'b0}};
    for (int i = 0; i < N; i++) begin
      acc = acc + CW'(v[i]);
    end
    return acc;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mode_q, mode_d;
  logic [N-1:0]     cand_q, cand_d;
  logic [CW-1:0]    rank_q, rank_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] buf_q [N];

  logic             in_xfer_s;
  logic [N-1:0]     colbit_s;
  logic [CW-1:0]    ones_s;
  logic [WIDTH-1:0] maj_s;

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign in_xfer_s     = bus.in_valid && (state_q == LOAD);

  // Column of bit b across all buffered samples, and the ones still in the candidate set.
  always_comb begin
    colbit_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      colbit_s[i] = buf_q[i][bit_q];
    end
    ones_s = popcount(cand_q & colbit_s);
  end

  // Legacy bitwise majority over the whole block, one column per result bit.
  always_comb begin
    logic [N-1:0] col;
    maj_s = {WIDTH{1'b0}};
    for (int b = 0; b < WIDTH; b++) begin
      col = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        col[i] = buf_q[i][b];
      end
      maj_s[b] = (popcount(col) >= CW'((N + 1) / 2));
    end
  end

  // Next-state and datapath updates for the LOAD / SEARCH / DONE sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mode_d      = mode_q;
    cand_d      = cand_q;
    rank_d      = rank_q;
    bit_d       = bit_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      LOAD: begin
        if (in_xfer_s) begin
          if (count_q == {CW{1'b0}}) begin
            mode_d = bus.mode;
          end else begin
            mode_d = mode_q;
          end
          if (count_q == CW'(N - 1)) begin
            count_d  = {CW{1'b0}};
            state_d  = SEARCH;
            cand_d   = {N{1'b1}};
            rank_d   = CW'((N + 1) / 2);
            bit_d    = BW'(WIDTH - 1);
            result_d = {WIDTH{1'b0}};
          end else begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          count_d = count_q;
        end
      end
      SEARCH: begin
        if (mode_q) begin
          result_d = maj_s;
          state_d  = DONE;
        end else begin
          // Enough candidates have a 1 here to contain the wanted rank: median bit is 1.
          if (ones_s >= rank_q) begin
            result_d[bit_q] = 1'b1;
            cand_d          = cand_q & colbit_s;
          end else begin
            result_d[bit_q] = 1'b0;
            rank_d          = rank_q - ones_s;
            cand_d          = cand_q & ~colbit_s;
          end
          if (bit_q == {BW{1'b0}}) begin
            state_d = DONE;
          end else begin
            bit_d = bit_q - {{(BW-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = result_q;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = LOAD;
        count_d     = {CW{1'b0}};
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and result registers; reset discards any partial block or search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      count_q     <= {CW{1'b0}};
      mode_q      <= 1'b0;
      cand_q      <= {N{1'b0}};
      rank_q      <= {CW{1'b0}};
      bit_q       <= {BW{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      cand_q      <= cand_d;
      rank_q      <= rank_d;
      bit_q       <= bit_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Sample buffer: each accepted sample lands in the slot given by the load count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_xfer_s && (count_q == CW'(i))) begin
          buf_q[i] <= bus.in_data;
        end else begin
          buf_q[i] <= buf_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_median_bitserial.sv
// Directed bench for median_bitserial (WIDTH=16, N=9).
module tb_median_bitserial;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   t_last;

  median_bitserial_if #(.WIDTH(16)) bus ();

  median_bitserial #(.WIDTH(16), .N(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure latency in cycles.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Feed nine samples; mode m0 on the first, m_rest afterwards; optional idle cycle between samples.
  task automatic send_block(input logic [15:0] s [9], input logic m0, input logic m_rest, input bit gaps);
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      bus.mode     = (i == 0) ? m0 : m_rest;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 16'hDEAD;
      if (gaps && i != 8) begin
        @(negedge clk);
      end
    end
    t_last = cyc;
  endtask

  // Wait (bounded) for out_valid and check latency and value.
  task automatic wait_result(input string tag, input logic [15:0] exp, input int exp_lat);
    int waited;
    waited = 0;
    while (!bus.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.out_valid) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"}, 32'(cyc - t_last), 32'(exp_lat));
      chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    end
  endtask

  // Accept the result and check the block returns to LOAD on the next cycle.
  task automatic finish_xfer(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ov_after"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] s [9], input logic m0, input logic m_rest,
                     input bit gaps, input logic [15:0] exp, input int exp_lat);
    send_block(s, m0, m_rest, gaps);
    wait_result(tag, exp, exp_lat);
    finish_xfer(tag);
  endtask

  logic [15:0] v_seq  [9] = '{16'd5, 16'd1, 16'd9, 16'd3, 16'd7, 16'd2, 16'd8, 16'd4, 16'd6};
  logic [15:0] v_dup  [9] = '{16'd7, 16'd7, 16'd7, 16'd1, 16'd1, 16'd1, 16'd9, 16'd9, 16'd9};
  logic [15:0] v_hi   [9] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF,
                              16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
  logic [15:0] v_lo   [9] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                              16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
  logic [15:0] v_mix  [9] = '{16'h3, 16'h5, 16'h6, 16'h3, 16'h5, 16'h6, 16'h3, 16'h5, 16'h6};
  logic [15:0] v_big  [9] = '{16'd1000, 16'd40000, 16'd20, 16'd65535, 16'd300,
                              16'd32768, 16'd7, 16'd50000, 16'd1234};

  initial begin
    logic [15:0] held;
    cyc           = 0;
    n_checks      = 0;
    n_pass        = 0;
    t_last        = 0;
    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("seq", v_seq, 1'b0, 1'b0, 1'b0, 16'd5, 17);
    run("dup", v_dup, 1'b0, 1'b0, 1'b0, 16'd7, 17);
    run("hi", v_hi, 1'b0, 1'b0, 1'b0, 16'hFFFF, 17);
    run("lo", v_lo, 1'b0, 1'b0, 1'b0, 16'h0000, 17);
    run("mix_med", v_mix, 1'b0, 1'b0, 1'b0, 16'h0005, 17);
    run("mix_maj", v_mix, 1'b1, 1'b1, 1'b0, 16'h0007, 2);
    // Sorted: 7,20,300,1000,1234,32768,40000,50000,65535 -> 1234.
    run("big", v_big, 1'b0, 1'b0, 1'b0, 16'd1234, 17);

    // Backpressure: result held, inputs blocked, stray in_valid ignored.
    bus.out_ready = 1'b0;
    send_block(v_dup, 1'b0, 1'b0, 1'b0);
    wait_result("bp", 16'd7, 17);
    held = bus.out_data;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.in_data  = 16'(16'h1111 * (k + 1));
      @(negedge clk);
      chk("bp_ov_hold", 32'(bus.out_valid), 32'd1);
      chk("bp_data_hold", 32'(bus.out_data), 32'(held));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    finish_xfer("bp");
    run("after_bp", v_seq, 1'b0, 1'b0, 1'b0, 16'd5, 17);

    // Gapped input with mode toggled after the first sample.
    run("gap_med", v_mix, 1'b0, 1'b1, 1'b1, 16'h0005, 17);
    run("gap_maj", v_mix, 1'b1, 1'b0, 1'b1, 16'h0007, 2);

    // Reset during SEARCH, then a fresh block.
    send_block(v_hi, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    run("post_rst", v_lo, 1'b0, 1'b0, 1'b0, 16'h0000, 17);
    run("post_rst2", v_seq, 1'b0, 1'b0, 1'b0, 16'd5, 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
